// File: rtl/serial_shift_tx.sv
// serial_shift_tx: parallel-in/serial-out transmitter, MSB first, with a framing strobe.
// Latency: first bit appears the cycle after the handshake; each bit is held BIT_CYCLES cycles.
// Backpressure: in_ready is high only in IDLE; words offered while busy are ignored.
// Optional macro TX_PARITY_EN appends an even-parity bit after bit 0.
module serial_shift_tx #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_data,
   output logic             ser_frame,
   output logic             busy,
   output logic             tx_done
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(BIT_CYCLES) + 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef TX_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif

   logic [1:0]       state;
   logic [BW-1:0]    bit_idx;
   logic [CW-1:0]    cyc_cnt;
   // Holds the bits still to be sent; the bit on the line is not kept here.
   logic [WIDTH-2:0] shreg;
`ifdef TX_PARITY_EN
   logic             par_bit;
`endif

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);

   // Frame sequencing: latch on handshake, hold each bit BIT_CYCLES cycles, then finish.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_idx   <= '0;
         cyc_cnt   <= '0;
         shreg     <= '0;
         ser_data  <= 1'b0;
         ser_frame <= 1'b0;
         tx_done   <= 1'b0;
`ifdef TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state     <= ST_SHIFT;
                  bit_idx   <= '0;
                  cyc_cnt   <= '0;
                  shreg     <= in_data[WIDTH-2:0];
                  ser_data  <= in_data[WIDTH-1];
                  ser_frame <= 1'b1;
`ifdef TX_PARITY_EN
                  par_bit   <= ^in_data;
`endif
               end
            end

            ST_SHIFT: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
`ifdef TX_PARITY_EN
                     state     <= ST_PARITY;
                     ser_data  <= par_bit;
`else
                     state     <= ST_IDLE;
                     ser_data  <= 1'b0;
                     ser_frame <= 1'b0;
                     tx_done   <= 1'b1;
`endif
                  end else begin
                     bit_idx  <= bit_idx + 1'b1;
                     ser_data <= shreg[WIDTH-2];
                     shreg    <= shreg << 1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end

`ifdef TX_PARITY_EN
            ST_PARITY: begin
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt   <= '0;
                  state     <= ST_IDLE;
                  ser_data  <= 1'b0;
                  ser_frame <= 1'b0;
                  tx_done   <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
`endif

            default: begin
               // Unreachable encodings recover quietly to IDLE without a done pulse.
               state     <= ST_IDLE;
               cyc_cnt   <= '0;
               bit_idx   <= '0;
               ser_data  <= 1'b0;
               ser_frame <= 1'b0;
            end
         endcase
      end
   end

endmodule
